// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: X/M -> data memory (req/ack) -> M/W; optional W->M store bypass via MEM_WM_BYPASS_EN.
// Latency: pass-through 0 cycles; loads/stores 2 + ack-delay stall cycles, abandoned after TIMEOUT+1 ACCESS cycles.
// Backpressure: holds stall high from the detect cycle until the access completes; dmem_req stays up until dmem_ack.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] xm_pc,
    input  logic [31:0] xm_o,
    input  logic [31:0] xm_b,
    input  logic [31:0] xm_ir,
    input  logic        xm_valid,
    input  logic        mw_wen,
    input  logic [4:0]  mw_rd,
    input  logic [31:0] mw_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] mw_pc_in,
    output logic [31:0] mw_o_in,
    output logic [31:0] mw_d_in,
    output logic [31:0] mw_ir_in,
    output logic        mem_err
);

    localparam logic [4:0]       OP_LW       = 5'b01000;
    localparam logic [4:0]       OP_SW       = 5'b00111;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_err;

    logic [4:0]        w_opcode;
    logic [4:0]        w_rd;
    logic              w_is_sw;
    logic              w_is_mem;
    logic [31:0]       w_store_data;
    logic              w_timeout;

    logic              w_stall;
    logic              w_req;
    logic              w_start;
    logic              w_capture;
    logic              w_expire;
    logic [31:0]       w_mw_pc;
    logic [31:0]       w_mw_o;
    logic [31:0]       w_mw_d;
    logic [31:0]       w_mw_ir;

    assign w_opcode  = xm_ir[31:27];
    assign w_rd      = xm_ir[26:22];
    assign w_is_sw   = (w_opcode == OP_SW);
    assign w_is_mem  = xm_valid && ((w_opcode == OP_LW) || w_is_sw);
    assign w_timeout = (r_cnt == TIMEOUT_CNT);

`ifdef MEM_WM_BYPASS_EN
    // A store whose source register is being written back this cycle takes the in-flight value.
    logic w_bypass_hit;
    assign w_bypass_hit = mw_wen && (mw_rd == w_rd) && (mw_rd != 5'd0);
    assign w_store_data = w_bypass_hit ? mw_data : xm_b;
`else
    logic w_unused_bypass;
    assign w_unused_bypass = &{1'b0, mw_wen, mw_rd, mw_data, w_rd};
    assign w_store_data    = xm_b;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_req       = 1'b0;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        w_mw_pc     = '0;
        w_mw_o      = '0;
        w_mw_d      = '0;
        w_mw_ir     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    w_stall     = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_mw_pc = xm_pc;
                    w_mw_o  = xm_o;
                    w_mw_ir = xm_ir;
                end
            end
            S_ACCESS: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (dmem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_timeout) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_mw_pc     = xm_pc;
                w_mw_o      = xm_o;
                w_mw_d      = r_rdata;
                w_mw_ir     = xm_ir;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_addr  <= xm_o;
                r_we    <= w_is_sw;
                r_wdata <= w_store_data;
                r_cnt   <= '0;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Stores complete with zero writeback data; an abandoned access also returns zero.
            if (w_capture) begin
                r_rdata <= r_we ? 32'd0 : dmem_rdata;
            end else if (w_expire) begin
                r_rdata   <= 32'd0;
                r_mem_err <= 1'b1;
            end
        end
    end

    // Combinational paths from X/M are blanked while reset is held so every output reads zero.
    assign stall      = reset & w_stall;
    assign dmem_req   = reset & w_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign mw_pc_in   = reset ? w_mw_pc : 32'd0;
    assign mw_o_in    = reset ? w_mw_o  : 32'd0;
    assign mw_d_in    = reset ? w_mw_d  : 32'd0;
    assign mw_ir_in   = reset ? w_mw_ir : 32'd0;
    assign mem_err    = r_mem_err;

endmodule
